// File: rtl/gate_truth_sweeper.sv
// Purpose: BIST sweeper that drives the four {a,b} input vectors into one 2-input
//          gate, samples gate_y per vector and grades it against a truth table.
// Latency: start at edge E0 gives a done pulse after edge E0+4*SETTLE_CYCLES+1.
// Backpressure: none; start is ignored while a sweep is in progress, with no queuing.
module gate_truth_sweeper #(
  parameter logic [3:0] EXPECTED      = 4'b0111,
  parameter int         SETTLE_CYCLES = 4,
  parameter int         CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             loop,
  output logic             gate_a,
  output logic             gate_b,
  input  logic             gate_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       fail_mask,
  output logic [3:0]       captured,
  output logic [CNT_W-1:0] fail_cnt
);

  // Settle counter must hold 0..SETTLE_CYCLES-1; keep at least one bit.
  localparam int CW = ($clog2(SETTLE_CYCLES + 1) < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FAIL_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       gate_ab_q, gate_ab_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [3:0]       fail_mask_q, fail_mask_d;
  logic [3:0]       captured_q, captured_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

  // Next-state and next-output logic for the sweep sequencer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fail_mask_d = fail_mask_q;
    captured_d  = captured_q;
    fail_cnt_d  = fail_cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = DRIVE;
          idx_d      = 2'd0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          captured_d = 4'b0000;
        end
      end

      DRIVE: begin
        if (cnt_q == CNT_LAST) begin
          // Last edge of this vector's settle window: gate_y is stable here.
          captured_d[idx_q] = gate_y;
          cnt_d             = '0;
          if (idx_q == 2'd3) begin
            state_d = REPORT;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      REPORT: begin
        pass_d      = (captured_q == EXPECTED);
        fail_mask_d = captured_q ^ EXPECTED;
        done_d      = 1'b1;
        if ((captured_q != EXPECTED) && (fail_cnt_q != FAIL_MAX)) begin
          fail_cnt_d = fail_cnt_q + CNT_W'(1);
        end
        idx_d = 2'd0;
        cnt_d = '0;
        if (loop) begin
          // Back-to-back sweep: busy stays high, no IDLE cycle in between.
          state_d    = DRIVE;
          busy_d     = 1'b1;
          captured_d = 4'b0000;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Gate inputs are registered so they present the vector of the next state.
    gate_ab_d = (state_d == DRIVE) ? idx_d : 2'b00;
  end

  // State and output registers; reset aborts any sweep without publishing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      cnt_q       <= '0;
      gate_ab_q   <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= 4'b0000;
      captured_q  <= 4'b0000;
      fail_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      gate_ab_q   <= gate_ab_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_mask_q <= fail_mask_d;
      captured_q  <= captured_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign gate_a    = gate_ab_q[1];
  assign gate_b    = gate_ab_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_mask_q;
  assign captured  = captured_q;
  assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_gate_truth_sweeper.sv
// Bench for gate_truth_sweeper: directed scenarios plus randomized traffic,
// checked every cycle against a sweep-position model and a few literal values.
module tb_gate_truth_sweeper;

  localparam int         S     = 4;
  localparam logic [3:0] EXP   = 4'b0111;
  localparam int         CNT_W = 8;
  localparam int         FMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             loop = 1'b0;
  logic             gate_a, gate_b, gate_y;
  logic             busy, done, pass;
  logic [3:0]       fail_mask, captured;
  logic [CNT_W-1:0] fail_cnt;

  int mode = 0;          // 0 NAND, 1 AND, 2 stuck-1, 3 stuck-0, 4 random
  bit y_rand = 1'b0;

  int errors = 0;
  int checks = 0;

  gate_truth_sweeper #(.EXPECTED(EXP), .SETTLE_CYCLES(S), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .loop(loop),
    .gate_a(gate_a), .gate_b(gate_b), .gate_y(gate_y),
    .busy(busy), .done(done), .pass(pass),
    .fail_mask(fail_mask), .captured(captured), .fail_cnt(fail_cnt)
  );

  // Gate under test.
  assign gate_y = (mode == 0) ? ~(gate_a & gate_b) :
                  (mode == 1) ?  (gate_a & gate_b) :
                  (mode == 2) ? 1'b1 :
                  (mode == 3) ? 1'b0 : y_rand;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_pos = -1 when idle, 0..4S-1 = cycle within the sweep, 4S = report cycle.
  int       m_pos = -1;
  bit [3:0] m_cap = 0, m_mask = 0;
  bit       m_pass = 0, m_done = 0, m_busy = 0;
  int       m_fc = 0;
  bit       s_start, s_loop, s_gy;

  always @(negedge clk) begin
    s_start = start;
    s_loop  = loop;
    s_gy    = gate_y;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos = -1; m_cap = 0; m_mask = 0; m_pass = 0; m_done = 0; m_busy = 0; m_fc = 0;
    end else begin
      m_done = 0;
      if (m_pos < 0) begin
        if (s_start) begin
          m_pos = 0; m_cap = 0; m_busy = 1;
        end
      end else if (m_pos < 4 * S) begin
        if (m_pos % S == S - 1) m_cap[m_pos / S] = s_gy;
        m_pos++;
      end else begin
        m_pass = (m_cap == EXP);
        m_mask = m_cap ^ EXP;
        m_done = 1;
        if (!m_pass && m_fc < FMAX) m_fc++;
        if (s_loop) begin
          m_pos = 0; m_cap = 0;
        end else begin
          m_pos = -1; m_busy = 0;
        end
      end
    end
  end

  function automatic logic [20:0] model_vec();
    int v;
    logic [1:0] ab;
    v = (m_pos >= 0 && m_pos < 4 * S) ? m_pos / S : 0;
    ab = 2'(v);
    return {ab, m_busy, m_done, m_pass, m_mask, m_cap, 8'(m_fc)};
  endfunction

  function automatic logic [20:0] dut_vec();
    return {gate_a, gate_b, busy, done, pass, fail_mask, captured, fail_cnt};
  endfunction

  // Cycle-by-cycle compare of every output against the model.
  always @(negedge clk) begin
    check("cycle", 32'(dut_vec()), 32'(model_vec()));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
    y_rand = 1'($urandom);
  endtask

  task automatic wait_done(input int maxc, output int k);
    k = 0;
    for (int i = 1; i <= maxc; i++) begin
      step();
      if (done) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int k;
    int nd;

    // Reset state.
    step();
    check("reset_outputs", 32'(dut_vec()), 32'd0);
    rst = 1'b0;
    step();

    // 1. Golden NAND: latency and vector sequence.
    mode = 0;
    start_pulse();
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 4)  check("vec_after_4", {30'd0, gate_a, gate_b}, 32'b01);
      if (i == 15) check("vec_after_15", {30'd0, gate_a, gate_b}, 32'b11);
      if (i == 16) check("vec_report", {30'd0, gate_a, gate_b}, 32'b00);
      if (done) begin k = i; break; end
    end
    check("golden_latency", k, 17);
    check("golden_captured", 32'(captured), 32'b0111);
    check("golden_mask", 32'(fail_mask), 32'b0000);
    check("golden_pass", 32'(pass), 32'd1);
    check("golden_fcnt", 32'(fail_cnt), 32'd0);
    check("golden_busy", 32'(busy), 32'd0);

    // 2. Wrong gate (AND).
    mode = 1;
    start_pulse();
    wait_done(40, k);
    check("and_latency", k, 17);
    check("and_captured", 32'(captured), 32'b1000);
    check("and_mask", 32'(fail_mask), 32'b1111);
    check("and_pass", 32'(pass), 32'd0);
    check("and_fcnt", 32'(fail_cnt), 32'd1);

    // 3. Stuck-at-1, two sweeps from a clean reset.
    pulse_reset();
    mode = 2;
    start_pulse();
    wait_done(40, k);
    check("s1_first", k, 17);
    start_pulse();
    wait_done(40, k);
    check("s1_second", k, 17);
    check("s1_captured", 32'(captured), 32'b1111);
    check("s1_mask", 32'(fail_mask), 32'b1000);
    check("s1_pass", 32'(pass), 32'd0);
    check("s1_fcnt", 32'(fail_cnt), 32'd2);

    // 4. Handshake: start while busy ignored; start in done cycle accepted.
    mode = 0;
    start_pulse();
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      start = (i == 3 || i == 9);
      if (done) begin k = i; break; end
    end
    start = 1'b0;
    check("busy_start_latency", k, 17);
    start_pulse();
    wait_done(40, k);
    check("done_cycle_restart", k, 17);
    check("restart_pass", 32'(pass), 32'd1);

    // 5. Asynchronous reset while idx=2.
    start_pulse();
    repeat (9) step();
    check("pre_reset_vec", {30'd0, gate_a, gate_b}, 32'b10);
    #1 rst = 1'b1;
    #1 check("async_reset", 32'(dut_vec()), 32'd0);
    step();
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) nd++;
    end
    check("no_done_after_reset", nd, 0);
    start_pulse();
    wait_done(40, k);
    check("post_reset_latency", k, 17);
    check("post_reset_pass", 32'(pass), 32'd1);

    // 6. Loop with stuck-at-0: period, saturation, loop drop mid-sweep.
    pulse_reset();
    mode = 3;
    loop = 1'b1;
    start_pulse();
    wait_done(40, k);
    check("loop_first", k, 17);
    for (int n = 2; n <= 300; n++) begin
      wait_done(40, k);
      check("loop_period", k, 17);
      if (n == 255) check("sat_at_255", 32'(fail_cnt), 32'd255);
    end
    check("sat_at_300", 32'(fail_cnt), 32'd255);
    repeat (5) step();
    loop = 1'b0;
    wait_done(40, k);
    check("loop_drop_latency", k, 12);
    check("loop_drop_busy", 32'(busy), 32'd0);
    check("loop_drop_mask", 32'(fail_mask), 32'b0111);

    // Randomized traffic against the model.
    pulse_reset();
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) loop = 1'($urandom);
      if ($urandom_range(0, 99) == 0) mode = $urandom_range(0, 4);
      step();
    end
    start = 1'b0;
    loop = 1'b0;
    repeat (40) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
